// File: rtl/i_buf_if.sv
// Pad-side bundle for i_buf: raw asynchronous input and the filtered level, edge pulses and edge count.
interface i_buf_if;
  logic       I;
  logic       O;
  logic       rise;
  logic       fall;
  logic [7:0] edge_count;

  modport master (output I, input O, rise, fall, edge_count);
  modport slave  (input I, output O, rise, fall, edge_count);
endinterface

// File: rtl/i_buf.sv
// Input buffer for an asynchronous pad: multi-flop synchronizer followed by a
// consecutive-cycle glitch filter, with registered edge pulses and an edge counter.
module i_buf #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter logic INIT        = 1'b0
) (
  input  logic   osc,
  input  logic   rst,
  i_buf_if.slave bus
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_o;
  logic                   r_rise;
  logic                   r_fall;
  logic [7:0]             r_cnt;
  logic [7:0]             r_edge_count;

  logic                   w_s;
  logic                   w_diff;
  logic                   w_accept;
  logic [8:0]             w_cnt_inc;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_diff    = (w_s != r_o);
  // 9-bit compare so FILTER_LEN up to 255 never aliases through an 8-bit wrap
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_accept  = w_diff && (w_cnt_inc == 9'(FILTER_LEN));

  always_ff @(posedge osc) begin
    if (rst) begin
      r_sync       <= {SYNC_STAGES{INIT}};
      r_o          <= INIT;
      r_cnt        <= 8'd0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_edge_count <= 8'd0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.I};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_diff) begin
        r_cnt <= 8'd0;
      end else if (w_accept) begin
        r_o          <= w_s;
        r_cnt        <= 8'd0;
        r_rise       <= w_s;
        r_fall       <= ~w_s;
        r_edge_count <= r_edge_count + 8'd1;
      end else begin
        r_cnt <= w_cnt_inc[7:0];
      end
    end
  end

  assign bus.O          = r_o;
  assign bus.rise       = r_rise;
  assign bus.fall       = r_fall;
  assign bus.edge_count = r_edge_count;

endmodule

// File: tb/tb_i_buf.sv
// Scoreboard bench for i_buf: default instance (2 sync, filter 4) and a fast
// instance (3 sync, filter 1); expected pulses are queued when I is driven.
module tb_i_buf;

  logic osc = 1'b0;
  logic rst;
  int   cyc = 0;

  i_buf_if bus_a ();
  i_buf_if bus_b ();

  i_buf dut_a (
    .osc (osc),
    .rst (rst),
    .bus (bus_a)
  );

  i_buf #(
    .SYNC_STAGES (3),
    .FILTER_LEN  (1),
    .INIT        (1'b0)
  ) dut_b (
    .osc (osc),
    .rst (rst),
    .bus (bus_b)
  );

  always #21 osc = ~osc;
  always @(posedge osc) cyc <= cyc + 1;

  typedef struct {
    logic       dir;
    int         cyc;
    logic [7:0] ec;
  } exp_t;

  exp_t       q_a[$];
  exp_t       q_b[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_rise_a = 0;
  int         n_fall_a = 0;
  logic       o_a = 1'b0;
  logic       o_b = 1'b0;
  logic [7:0] ec_a = 8'd0;
  logic [7:0] ec_b = 8'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge osc);
    #1;
  endtask

  // A change held for at least FILTER_LEN cycles is accepted SYNC+FILTER edges later
  task automatic drive_a(input logic v, input int hold);
    exp_t e;
    bus_a.I = v;
    if (v !== o_a && hold >= 4) begin
      ec_a  = ec_a + 8'd1;
      e.dir = v;
      e.cyc = cyc + 6;
      e.ec  = ec_a;
      q_a.push_back(e);
      o_a   = v;
    end
    tick(hold);
  endtask

  task automatic drive_b(input logic v, input int hold);
    exp_t e;
    bus_b.I = v;
    if (v !== o_b && hold >= 1) begin
      ec_b  = ec_b + 8'd1;
      e.dir = v;
      e.cyc = cyc + 4;
      e.ec  = ec_b;
      q_b.push_back(e);
      o_b   = v;
    end
    tick(hold);
  endtask

  always @(negedge osc) begin : mon_a
    exp_t e;
    if (bus_a.rise === 1'b1 || bus_a.fall === 1'b1) begin
      chk("a_excl", 32'(bus_a.rise & bus_a.fall), 32'd0);
      if (bus_a.rise) n_rise_a++;
      else            n_fall_a++;
      if (q_a.size() == 0) begin
        chk("a_unexpected_pulse", 32'({bus_a.rise, bus_a.fall}), 32'd0);
      end else begin
        e = q_a.pop_front();
        chk("a_dir",   32'(bus_a.rise),       32'(e.dir));
        chk("a_cycle", 32'(cyc),              32'(e.cyc));
        chk("a_ec",    32'(bus_a.edge_count), 32'(e.ec));
        chk("a_O",     32'(bus_a.O),          32'(e.dir));
      end
    end
  end

  always @(negedge osc) begin : mon_b
    exp_t e;
    if (bus_b.rise === 1'b1 || bus_b.fall === 1'b1) begin
      chk("b_excl", 32'(bus_b.rise & bus_b.fall), 32'd0);
      if (q_b.size() == 0) begin
        chk("b_unexpected_pulse", 32'({bus_b.rise, bus_b.fall}), 32'd0);
      end else begin
        e = q_b.pop_front();
        chk("b_dir",   32'(bus_b.rise),       32'(e.dir));
        chk("b_cycle", 32'(cyc),              32'(e.cyc));
        chk("b_ec",    32'(bus_b.edge_count), 32'(e.ec));
        chk("b_O",     32'(bus_b.O),          32'(e.dir));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: run did not complete, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r0;
    int f0;
    rst     = 1'b1;
    bus_a.I = 1'b0;
    bus_b.I = 1'b0;

    // reset for two edges, I low
    tick(2);
    chk("a_rst_O",    32'(bus_a.O),          32'd0);
    chk("a_rst_rise", 32'(bus_a.rise),       32'd0);
    chk("a_rst_fall", 32'(bus_a.fall),       32'd0);
    chk("a_rst_ec",   32'(bus_a.edge_count), 32'd0);
    chk("b_rst_O",    32'(bus_b.O),          32'd0);
    rst = 1'b0;
    tick(8);
    chk("a_idle_O", 32'(bus_a.O), 32'd0);

    // 0->1 held: O flips at edge 6 after the change
    drive_a(1'b1, 5);
    chk("a_lat_edge5_O", 32'(bus_a.O), 32'd0);
    tick(1);
    chk("a_lat_edge6_O", 32'(bus_a.O), 32'd1);
    tick(6);

    // low glitches shorter than the filter are swallowed
    for (int len = 1; len <= 3; len++) begin
      drive_a(1'b0, len);
      drive_a(1'b1, 8);
    end
    chk("a_glitch_O",  32'(bus_a.O),          32'd1);
    chk("a_glitch_ec", 32'(bus_a.edge_count), 32'd1);

    // 256 accepted toggles from a clean reset: counter wraps, equal rise/fall
    rst     = 1'b1;
    bus_a.I = 1'b0;
    tick(1);
    rst  = 1'b0;
    o_a  = 1'b0;
    ec_a = 8'd0;
    tick(4);
    r0 = n_rise_a;
    f0 = n_fall_a;
    for (int k = 0; k < 256; k++) begin
      drive_a((k % 2) == 0, 6);
    end
    tick(4);
    chk("a_wrap_rise_cnt", 32'(n_rise_a - r0),   32'd128);
    chk("a_wrap_fall_cnt", 32'(n_fall_a - f0),   32'd128);
    chk("a_wrap_ec",       32'(bus_a.edge_count), 32'd0);
    chk("a_wrap_O",        32'(bus_a.O),          32'd0);

    // reset lands at edge 4 of a filtered rise; partial count is discarded
    drive_a(1'b1, 3);
    rst = 1'b1;
    tick(1);
    chk("a_midrst_O",    32'(bus_a.O),          32'd0);
    chk("a_midrst_rise", 32'(bus_a.rise),       32'd0);
    chk("a_midrst_ec",   32'(bus_a.edge_count), 32'd0);
    rst  = 1'b0;
    o_a  = 1'b0;
    ec_a = 8'd0;
    drive_a(1'b1, 12);
    chk("a_postrst_O",  32'(bus_a.O),          32'd1);
    chk("a_postrst_ec", 32'(bus_a.edge_count), 32'd1);

    // fast instance: O at edge 4, then every single-cycle change accepted
    drive_b(1'b1, 3);
    chk("b_lat_edge3_O", 32'(bus_b.O), 32'd0);
    tick(1);
    chk("b_lat_edge4_O", 32'(bus_b.O), 32'd1);
    tick(4);
    for (int k = 0; k < 6; k++) begin
      drive_b((k % 2) == 1, 1);
    end
    tick(8);
    chk("b_final_ec", 32'(bus_b.edge_count), 32'd7);

    chk("a_sb_empty", 32'(q_a.size()), 32'd0);
    chk("b_sb_empty", 32'(q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i_buf.md
I_BUF -- requirements
Module: i_buf

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on I; legal range 2..4.
REQ-002 Parameter FILTER_LEN, default 4, consecutive synchronized cycles a new level must hold before acceptance; legal range 1..255.
REQ-003 Parameter INIT, default 1'b0, level of O and all synchronizer flops after reset.
REQ-004 osc  input  1  sole clock (24 MHz); all state updates on posedge osc.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 I  input  1  asynchronous pad input.
REQ-007 O  output  1  synchronized, glitch-filtered registered level of I.
REQ-008 rise  output  1  one-cycle pulse on an accepted 0->1 transition of O.
REQ-009 fall  output  1  one-cycle pulse on an accepted 1->0 transition of O.
REQ-010 edge_count  output  8  count of accepted transitions of O, in either direction.

Function
REQ-011 I SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the sample s; no combinational path from I to any output.
REQ-012 An internal counter cnt, 8-bit, SHALL clear when s equals O and increment when s differs from O.
REQ-013 When s differs from O and cnt+1 equals FILTER_LEN: O SHALL take the value of s, cnt SHALL clear, and exactly one of rise or fall SHALL assert for that cycle.
REQ-014 Latency: with I stable after a change ahead of edge 1, O SHALL change at edge SYNC_STAGES+FILTER_LEN (edge 6 with defaults); rise or fall SHALL be high during the cycle following that edge only.
REQ-015 Glitch rule: a difference between s and O lasting fewer than FILTER_LEN consecutive cycles SHALL leave O unchanged, assert no pulse, and return cnt to 0.
REQ-016 With FILTER_LEN=1, O SHALL follow s one cycle late, and every change of s SHALL be accepted.
REQ-017 rise and fall SHALL never be high in the same cycle.
REQ-018 rise and fall SHALL each be low in every cycle that does not directly follow an accepted transition.
REQ-019 edge_count SHALL increment by 1 on the same edge that O changes, and SHALL wrap from 255 to 0.
REQ-020 cnt SHALL never exceed FILTER_LEN-1.

Reset
REQ-021 When rst is high at a posedge osc, the block SHALL set: all synchronizer flops to INIT, O to INIT, cnt to 0, rise to 0, fall to 0, edge_count to 0.
REQ-022 rst SHALL take priority over all other updates in the same cycle.
REQ-023 A reset applied while a transition is being filtered SHALL discard the partial count.
REQ-024 After rst deasserts with I equal to INIT, no pulse SHALL occur.
REQ-025 After rst deasserts with I not equal to INIT, the transition SHALL be accepted through the normal filter path with normal latency.
REQ-026 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-027 Defaults; rst high 2 cycles, I=0 -> O=0, rise=fall=0, edge_count=0.
REQ-028 Defaults; I 0->1 held -> O=1 at edge 6, rise high 1 cycle, edge_count=1.
REQ-029 Defaults, O=1; I low for 3 cycles, then high -> O stays 1, no fall pulse, edge_count unchanged.
REQ-030 Defaults; toggle I with an accepted change 256 times -> edge_count wraps to 0, rise and fall pulse counts equal 128 each.
REQ-031 Defaults; I 0->1, assert rst at edge 4 -> O=0, no pulse; after release, O=1 six edges later.
REQ-032 FILTER_LEN=1, SYNC_STAGES=3; I 0->1 -> O=1 at edge 4, rise high 1 cycle.
